// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO.
// Configurable framing; frames go out back to back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic                 tx_n, busy_n;
  logic                 bit_end;
  logic                 head_par;

  assign wr_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rd_ptr];
  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
  assign head_par = (PARITY == 2) ? ^head : ~^head;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Frame sequencing; line level computed one cycle ahead
  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_bit;
    pop     = 1'b0;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    unique case (state)
      IDLE: begin
        busy_n  = 1'b0;
        timer_n = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = head_par;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end) begin
          timer_n = '0;
          shift_n = shift >> 1;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PAR: begin
        tx_n = par_bit;
        if (bit_end) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          if (idx == IW'(STOP_BITS - 1)) begin
            idx_n = '0;
            if (fifo_count != '0) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = head_par;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: several framing variants side by side,
// directed line vectors plus random traffic vs a queue model.
module tb_uart_tx_fifo;

  localparam int N   = 6;
  localparam int CPB = 4;

  function automatic int db_of(int k);
    return (k == 4) ? 7 : (k == 5) ? 9 : 8;
  endfunction
  function automatic int pb_of(int k);
    return (k == 1) ? 2 : (k == 2 || k == 5) ? 1 : 0;
  endfunction
  function automatic int sb_of(int k);
    return (k == 3 || k == 5) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] wr_data    [N];
  logic       wr_valid   [N];
  logic       wr_ready   [N];
  logic       tx         [N];
  logic       busy       [N];
  logic [4:0] fifo_count [N];

  logic [8:0] expq [N][64];
  int         head [N];
  int         tail [N];
  int         rx_cnt [N];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic put(int k, logic [8:0] d);
    expq[k][tail[k] % 64] = d;
    tail[k]++;
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DB = db_of(g);
    localparam int PB = pb_of(g);
    localparam int SB = sb_of(g);
    localparam int L  = 1 + DB + ((PB != 0) ? 1 : 0) + SB;

    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS(DB),
      .PARITY(PB),
      .STOP_BITS(SB),
      .FIFO_DEPTH(16)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .wr_data(wr_data[g][DB-1:0]),
      .wr_valid(wr_valid[g]),
      .wr_ready(wr_ready[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .fifo_count(fifo_count[g])
    );

    logic [15:0] fr;
    logic [15:0] ex;
    logic [8:0]  e;
    int          pos;
    int          ones;
    bit          act;
    bit          pend;

    // Serial receiver: mid-bit sampling, frame vs model queue
    always @(posedge clk) begin
      #2;
      if (rst) begin
        act = 0;
        head[g] = 0;
        tail[g] = 0;
        rx_cnt[g] = 0;
      end else if (!act) begin
        if (tx[g] == 1'b0) begin
          act = 1;
          pos = 0;
          fr  = '0;
        end
      end else begin
        pos++;
        if (pos % CPB == CPB / 2) fr[pos / CPB] = tx[g];
        if (pos == CPB * (L - 1) + CPB / 2) begin
          act = 0;
          rx_cnt[g]++;
          pend = (tail[g] != head[g]);
          chk($sformatf("pending%0d", g), 32'(pend), 1);
          if (pend) begin
            e = expq[g][head[g] % 64];
            head[g]++;
            ex = '0;
            ones = 0;
            for (int i = 0; i < DB; i++) begin
              ex[1 + i] = e[i];
              if (e[i]) ones++;
            end
            if (PB == 2) ex[1 + DB] = (ones % 2 == 1);
            if (PB == 1) ex[1 + DB] = (ones % 2 == 0);
            for (int j = 0; j < SB; j++)
              ex[L - 1 - j] = 1'b1;
            chk($sformatf("frame%0d", g), 32'(fr), 32'(ex));
          end
        end
      end
    end
  end

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) wr_valid[k] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Samples the line CPB times per expected bit
  task automatic expect_line(int k, string s);
    int nb;
    logic want;
    logic got;
    nb = 0;
    for (int i = 0; i < s.len(); i++) begin
      want = (s[i] == 8'h31);
      got  = want;
      for (int c = 0; c < CPB; c++) begin
        if (tx[k] !== want) got = tx[k];
        if (busy[k] !== 1'b1) nb++;
        @(negedge clk);
      end
      chk($sformatf("k%0d_bit%0d", k, i), 32'(got), 32'(want));
    end
    chk($sformatf("k%0d_busy_hi", k), nb, 0);
  endtask

  typedef struct {
    int         k;
    int         nw;
    logic [8:0] d0;
    logic [8:0] d1;
    string      bits;
  } vec_t;

  vec_t vt [6];
  int   acc;
  bit   rdy;
  bit   done;
  int   dens;
  int   qtx;
  int   qbusy;
  logic [8:0] d;

  initial begin
    vt[0] = '{0, 1, 9'h0A5, 9'h000, "0101001011"};
    vt[1] = '{1, 1, 9'h0A5, 9'h000, "01010010101"};
    vt[2] = '{2, 1, 9'h007, 9'h000, "01110000001"};
    vt[3] = '{2, 1, 9'h003, 9'h000, "01100000011"};
    vt[4] = '{4, 1, 9'h055, 9'h000, "010101011"};
    vt[5] = '{3, 2, 9'h03C, 9'h0C3,
              "0001111001101100001111"};

    for (int k = 0; k < N; k++) begin
      wr_valid[k] = 1'b0;
      wr_data[k]  = '0;
      head[k] = 0;
      tail[k] = 0;
      rx_cnt[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_tx%0d", k), 32'(tx[k]), 1);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
      chk($sformatf("rst_rdy%0d", k), 32'(wr_ready[k]), 1);
      chk($sformatf("rst_cnt%0d", k), 32'(fifo_count[k]), 0);
    end

    // Directed frames: latency, bit timing, back-to-back
    for (int v = 0; v < 6; v++) begin
      reset_all();
      wr_valid[vt[v].k] = 1'b1;
      wr_data[vt[v].k]  = vt[v].d0;
      put(vt[v].k, vt[v].d0);
      @(negedge clk);
      chk($sformatf("v%0d_lat0", v), 32'(tx[vt[v].k]), 1);
      if (vt[v].nw == 2) begin
        wr_data[vt[v].k] = vt[v].d1;
        put(vt[v].k, vt[v].d1);
      end else begin
        wr_valid[vt[v].k] = 1'b0;
      end
      @(negedge clk);
      wr_valid[vt[v].k] = 1'b0;
      chk($sformatf("v%0d_lat1", v), 32'(tx[vt[v].k]), 1);
      @(negedge clk);
      expect_line(vt[v].k, vt[v].bits);
      chk($sformatf("v%0d_idle", v), 32'(busy[vt[v].k]), 0);
      chk($sformatf("v%0d_cnt", v),
          32'(fifo_count[vt[v].k]), 0);
    end

    // Capacity burst with incrementing data
    reset_all();
    acc = 0;
    wr_valid[0] = 1'b1;
    wr_data[0]  = '0;
    for (int e = 0; e <= 16; e++) begin
      rdy = wr_ready[0];
      if (rdy) put(0, wr_data[0]);
      @(negedge clk);
      if (rdy) begin
        acc++;
        wr_data[0] = 9'(acc);
      end
    end
    wr_valid[0] = 1'b0;
    chk("burst_acc", acc, 17);
    chk("burst_cnt", 32'(fifo_count[0]), 16);
    chk("burst_rdy", 32'(wr_ready[0]), 0);
    repeat (24) @(negedge clk);
    chk("rdy_before_pop", 32'(wr_ready[0]), 0);
    @(negedge clk);
    chk("rdy_after_pop", 32'(wr_ready[0]), 1);
    done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      done = (head[0] == tail[0]) && !busy[0];
    end
    chk("burst_drain", tail[0] - head[0], 0);
    chk("burst_rx", rx_cnt[0], 17);

    // Reset in the middle of the first data bit run
    reset_all();
    wr_valid[0] = 1'b1;
    wr_data[0]  = 9'h011;
    put(0, 9'h011);
    @(negedge clk);
    wr_data[0] = 9'h022;
    put(0, 9'h022);
    @(negedge clk);
    wr_data[0] = 9'h033;
    put(0, 9'h033);
    @(negedge clk);
    wr_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", 32'(tx[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_cnt", 32'(fifo_count[0]), 0);
    chk("abort_rdy", 32'(wr_ready[0]), 1);
    qtx = 0;
    qbusy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) qtx++;
      if (busy[0] !== 1'b0) qbusy++;
    end
    chk("quiet_tx", qtx, 0);
    chk("quiet_busy", qbusy, 0);
    chk("quiet_rx", rx_cnt[0], 0);

    // Random traffic on every variant
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      dens = ((c / 300) % 2 == 0) ? 3 : 1;
      for (int k = 0; k < N; k++) begin
        wr_valid[k] = ($urandom_range(3) < dens);
        d = 9'($urandom & ((1 << db_of(k)) - 1));
        wr_data[k] = d;
        if (wr_valid[k] && wr_ready[k]) put(k, d);
      end
      @(negedge clk);
    end
    for (int k = 0; k < N; k++) wr_valid[k] = 1'b0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = 1;
      for (int k = 0; k < N; k++)
        if (head[k] != tail[k] || busy[k]) done = 0;
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rand_drain%0d", k), tail[k] - head[k], 0);
      chk($sformatf("rand_cnt%0d", k),
          32'(fifo_count[k]), 0);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
